apb4_master_arbiter: RTL and testbench

Two-requester APB4 master that shares one APB4 bus between two internal command sources (e.g. CPU bridge and DMA) and drives the APB4 slave interfaces of the register blocks. Round-robin arbitration picks a requester, latches its command, and sequences the APB SETUP/ACCESS phases, honouring `pready` wait states and `pslverr`. Completion is returned to the winning requester as a one-cycle `done` pulse with registered read data and error.

---
 rtl/apb4_arb_pkg.sv | 11 +
 rtl/apb4_rr_arbiter.sv | 14 +
 rtl/apb4_master_arbiter.sv | 110 +++++++++++
 tb/tb_apb4_master_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/apb4_arb_pkg.sv
// apb4_arb_pkg: shared state encoding and bus constants for the APB4 master arbiter
package apb4_arb_pkg;
  localparam int DATA_W = 32;
  localparam int STROBE_W = 4;
  localparam int DEF_TIMEOUT = 16;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;
endpackage

// File: rtl/apb4_rr_arbiter.sv
// apb4_rr_arbiter: 2-way round-robin arbiter, one-hot grant, history updated on strobe
module apb4_rr_arbiter (
  input  logic       pclk,
  input  logic       preset,
  input  logic [1:0] eligible,
  input  logic       update,
  output logic [1:0] grant,
  output logic       last_gnt
);
  always_comb grant = &eligible ? (last_gnt ? 2'b01 : 2'b10) : eligible;
  always_ff @(posedge pclk or posedge preset)
    if (preset) last_gnt <= 1'b1;
    else if (update) last_gnt <= grant[1];
endmodule

// File: rtl/apb4_master_arbiter.sv
// apb4_master_arbiter: two-requester APB4 master with round-robin arbitration
// Optional ACCESS timeout compiled in with `define APB_ARB_TIMEOUT_EN
module apb4_master_arbiter
  import apb4_arb_pkg::*;
#(
  parameter int ADDRWIDTH = 12,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                 pclk,
  input  logic                 preset,
  input  logic                 req0,
  input  logic                 req0_write,
  input  logic [ADDRWIDTH-1:0] req0_addr,
  input  logic [DATA_W-1:0]    req0_wdata,
  input  logic [STROBE_W-1:0]  req0_strb,
  output logic                 req0_done,
  output logic [DATA_W-1:0]    req0_rdata,
  output logic                 req0_err,
  input  logic                 req1,
  input  logic                 req1_write,
  input  logic [ADDRWIDTH-1:0] req1_addr,
  input  logic [DATA_W-1:0]    req1_wdata,
  input  logic [STROBE_W-1:0]  req1_strb,
  output logic                 req1_done,
  output logic [DATA_W-1:0]    req1_rdata,
  output logic                 req1_err,
  output logic                 psel,
  output logic                 penable,
  output logic                 pwrite,
  output logic [ADDRWIDTH-1:0] paddr,
  output logic [DATA_W-1:0]    pwdata,
  output logic [STROBE_W-1:0]  pstrb,
  input  logic [DATA_W-1:0]    prdata,
  input  logic                 pready,
  input  logic                 pslverr
);
  apb_state_e state;
  logic own;
  logic [1:0] eligible, grant;
  logic last_gnt, start, expired, finish, err_val, sel_write;
  logic [DATA_W-1:0] rd_val;
  // a requester in its done cycle is masked so a held req counts as a fresh request
  assign eligible = {req1 & ~req1_done, req0 & ~req0_done};
  assign start = state == IDLE && |eligible;
  assign finish = state == ACCESS && (pready || expired);
  assign rd_val = pready && !pwrite ? prdata : '0;
  assign err_val = !pready || pslverr;
  assign sel_write = grant[1] ? req1_write : req0_write;
  apb4_rr_arbiter u_rr (
    .pclk     (pclk),
    .preset   (preset),
    .eligible (eligible),
    .update   (start),
    .grant    (grant),
    .last_gnt (last_gnt)
  );
`ifdef APB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] acc_cnt;
  always_ff @(posedge pclk or posedge preset)
    if (preset) acc_cnt <= '0;
    else acc_cnt <= state == ACCESS ? acc_cnt + 1'b1 : '0;
  assign expired = state == ACCESS && !pready && acc_cnt == CNT_W'(TIMEOUT - 1);
`else
  localparam int unused_timeout = TIMEOUT;
  assign expired = 1'b0;
`endif
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state <= IDLE;
      own <= 1'b0;
      psel <= 1'b0;
      penable <= 1'b0;
      pwrite <= 1'b0;
      paddr <= '0;
      pwdata <= '0;
      pstrb <= '0;
      req0_done <= 1'b0;
      req1_done <= 1'b0;
      req0_rdata <= '0;
      req1_rdata <= '0;
      req0_err <= 1'b0;
      req1_err <= 1'b0;
    end else begin
      req0_done <= finish & ~own;
      req1_done <= finish & own;
      req0_rdata <= finish & ~own ? rd_val : '0;
      req1_rdata <= finish & own ? rd_val : '0;
      req0_err <= finish & ~own & err_val;
      req1_err <= finish & own & err_val;
      if (start) begin
        state <= SETUP;
        own <= grant[1];
        psel <= 1'b1;
        penable <= 1'b0;
        pwrite <= sel_write;
        paddr <= grant[1] ? req1_addr : req0_addr;
        pwdata <= grant[1] ? req1_wdata : req0_wdata;
        pstrb <= sel_write ? (grant[1] ? req1_strb : req0_strb) : '0;
      end else if (state == SETUP) begin
        state <= ACCESS;
        penable <= 1'b1;
      end else if (finish) begin
        state <= IDLE;
        psel <= 1'b0;
        penable <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_apb4_master_arbiter.sv
// tb_apb4_master_arbiter: directed plan cases plus randomized traffic against a transfer-level model
module tb_apb4_master_arbiter;
  logic pclk = 1'b0;
  logic preset;
  logic r_req [2];
  logic r_write [2];
  logic [11:0] r_addr [2];
  logic [31:0] r_wdata [2];
  logic [3:0] r_strb [2];
  logic req0_done, req1_done, req0_err, req1_err;
  logic [31:0] req0_rdata, req1_rdata;
  logic psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata, prdata;
  logic [3:0] pstrb;
  logic pready, pslverr;
  int checks = 0;
  int errors = 0;
  always #5 pclk = ~pclk;
  apb4_master_arbiter #(.ADDRWIDTH(12), .TIMEOUT(16)) dut (
    .pclk(pclk), .preset(preset),
    .req0(r_req[0]), .req0_write(r_write[0]), .req0_addr(r_addr[0]), .req0_wdata(r_wdata[0]),
    .req0_strb(r_strb[0]), .req0_done(req0_done), .req0_rdata(req0_rdata), .req0_err(req0_err),
    .req1(r_req[1]), .req1_write(r_write[1]), .req1_addr(r_addr[1]), .req1_wdata(r_wdata[1]),
    .req1_strb(r_strb[1]), .req1_done(req1_done), .req1_rdata(req1_rdata), .req1_err(req1_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pstrb(pstrb), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge pclk);
    #1;
  endtask
  task automatic set_req(input int i, input logic w, input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    r_req[i] = 1'b1;
    r_write[i] = w;
    r_addr[i] = a;
    r_wdata[i] = d;
    r_strb[i] = s;
  endtask
  task automatic new_cmd(input int i);
    set_req(i, 1'($urandom_range(0, 1)), 12'($urandom), $urandom, 4'($urandom));
  endtask
  task automatic do_reset;
    preset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      r_req[i] = 1'b0;
      r_write[i] = 1'b0;
      r_addr[i] = '0;
      r_wdata[i] = '0;
      r_strb[i] = '0;
    end
    pready = 1'b0;
    prdata = '0;
    pslverr = 1'b0;
    repeat (2) @(posedge pclk);
    #1 preset = 1'b0;
  endtask
  int ph, own, last, w;
  logic [1:0] md, nd, elig;
  logic [31:0] mrd, mwd;
  logic merr, mw;
  logic [11:0] ma;
  logic [3:0] ms;
  initial begin
    do_reset;
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    check("rst_pwrite", pwrite, 0);
    check("rst_paddr", paddr, 0);
    check("rst_pwdata", pwdata, 0);
    check("rst_pstrb", pstrb, 0);
    check("rst_done", {req1_done, req0_done}, 0);
    check("rst_rdata", {req1_rdata, req0_rdata}, 0);
    check("rst_err", {req1_err, req0_err}, 0);
    // zero-wait read from requester 0
    set_req(0, 1'b0, 12'h010, 32'h0, 4'hf);
    pready = 1'b1;
    prdata = 32'hDEADBEEF;
    tick;
    check("rd_setup", {psel, penable}, 2'b10);
    check("rd_paddr", paddr, 12'h010);
    check("rd_pwrite", pwrite, 0);
    check("rd_pstrb", pstrb, 0);
    tick;
    check("rd_access", {psel, penable}, 2'b11);
    tick;
    check("rd_done", {req1_done, req0_done}, 2'b01);
    check("rd_rdata", req0_rdata, 32'hDEADBEEF);
    check("rd_err", req0_err, 0);
    check("rd_psel_drop", psel, 0);
    r_req[0] = 1'b0;
    tick;
    check("rd_done_pulse", req0_done, 0);
    // write from requester 1 with three wait states
    set_req(1, 1'b1, 12'h024, 32'h12345678, 4'h3);
    pready = 1'b0;
    tick;
    check("wr_setup", {psel, penable}, 2'b10);
    for (int i = 0; i < 4; i++) begin
      tick;
      check("wr_access", {psel, penable, pwrite}, 3'b111);
      check("wr_paddr", paddr, 12'h024);
      check("wr_pwdata", pwdata, 32'h12345678);
      check("wr_pstrb", pstrb, 4'h3);
      check("wr_no_done", {req1_done, req0_done}, 0);
      pready = i == 3;
    end
    tick;
    check("wr_done", {req1_done, req0_done}, 2'b10);
    check("wr_rdata", req1_rdata, 0);
    check("wr_err", req1_err, 0);
    r_req[1] = 1'b0;
    tick;
    // both requesters held for four transfers
    set_req(0, 1'b0, 12'h100, 32'h0, 4'h0);
    set_req(1, 1'b0, 12'h200, 32'h0, 4'h0);
    pready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      w = t % 2;
      prdata = 32'hA5A50000 + t;
      tick;
      check("rr_setup", {psel, penable}, 2'b10);
      check("rr_paddr", paddr, w ? 12'h200 : 12'h100);
      tick;
      check("rr_access", penable, 1);
      tick;
      check("rr_done", {req1_done, req0_done}, w ? 2'b10 : 2'b01);
      check("rr_rdata", w ? req1_rdata : req0_rdata, 32'hA5A50000 + t);
      check("rr_other_rdata", w ? req0_rdata : req1_rdata, 0);
    end
    r_req[0] = 1'b0;
    r_req[1] = 1'b0;
    tick;
    // slave error on a read
    set_req(0, 1'b0, 12'h030, 32'h0, 4'h0);
    pslverr = 1'b1;
    repeat (3) tick;
    check("err_done", req0_done, 1);
    check("err_flag", req0_err, 1);
    r_req[0] = 1'b0;
    pslverr = 1'b0;
    tick;
    // slave that never answers
    set_req(0, 1'b0, 12'h040, 32'h0, 4'h0);
    pready = 1'b0;
    prdata = 32'hFFFFFFFF;
    tick;
`ifdef APB_ARB_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      tick;
      check("to_access", {psel, penable}, 2'b11);
    end
    tick;
    check("to_psel", psel, 0);
    check("to_done", req0_done, 1);
    check("to_err", req0_err, 1);
    check("to_rdata", req0_rdata, 0);
`else
    repeat (100) tick;
    check("hang_psel", {psel, penable}, 2'b11);
    check("hang_no_done", req0_done, 0);
    pready = 1'b1;
    tick;
    check("hang_done", req0_done, 1);
`endif
    r_req[0] = 1'b0;
    tick;
    // reset in ACCESS, then both pending
    set_req(0, 1'b0, 12'h055, 32'h0, 4'h0);
    pready = 1'b0;
    tick;
    tick;
    check("ar_access", penable, 1);
    preset = 1'b1;
    #1;
    check("ar_async", {psel, penable}, 0);
    set_req(1, 1'b1, 12'h0AA, 32'h1, 4'h1);
    tick;
    check("ar_no_done", {req1_done, req0_done}, 0);
    preset = 1'b0;
    tick;
    check("ar_setup", {psel, penable}, 2'b10);
    check("ar_paddr", paddr, 12'h055);
    pready = 1'b1;
    tick;
    tick;
    check("ar_done", {req1_done, req0_done}, 2'b01);
    r_req[0] = 1'b0;
    r_req[1] = 1'b0;
    tick;
    // randomized traffic
    do_reset;
    ph = 0; own = 0; last = 1; md = '0; mw = 1'b0; ma = '0; mwd = '0; ms = '0; mrd = '0; merr = 1'b0;
    for (int cyc = 0; cyc < 560; cyc++) begin
      elig = {r_req[1], r_req[0]} & ~md;
      nd = '0;
      if (ph == 0) begin
        if (elig != 0) begin
          own = elig == 2'b11 ? 1 - last : (elig[1] ? 1 : 0);
          last = own;
          mw = r_write[own];
          ma = r_addr[own];
          mwd = r_wdata[own];
          ms = mw ? r_strb[own] : 4'h0;
          ph = 1;
        end
      end else if (ph == 1) ph = 2;
      else if (pready) begin
        nd[own] = 1'b1;
        mrd = mw ? 32'h0 : prdata;
        merr = pslverr;
        ph = 0;
      end
      md = nd;
      tick;
      check("rnd_psel", psel, ph != 0);
      check("rnd_penable", penable, ph == 2);
      check("rnd_done", {req1_done, req0_done}, md);
      check("rnd_cmd", {pwrite, paddr, pwdata, pstrb}, {mw, ma, mwd, ms});
      if (md != 0) begin
        check("rnd_rdata", own ? req1_rdata : req0_rdata, mrd);
        check("rnd_err", own ? req1_err : req0_err, merr);
        check("rnd_other", own ? {req0_rdata, req0_err} : {req1_rdata, req1_err}, 0);
      end
      for (int i = 0; i < 2; i++) begin
        if (md[i]) begin
          r_req[i] = cyc < 480 && $urandom_range(0, 3) == 0;
          if (r_req[i]) new_cmd(i);
        end else if (!r_req[i] && cyc < 480 && $urandom_range(0, 2) == 0) new_cmd(i);
      end
      pready = $urandom_range(0, 2) != 0;
      prdata = $urandom;
      pslverr = $urandom_range(0, 3) == 0;
    end
    check("drain_req", {r_req[1], r_req[0]}, 0);
    check("drain_psel", psel, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
